// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vector-multiply sequencer: FSM states and
// default parameter values.
package vec_mul_pkg;
   localparam int ADDRESSSIZE_DEF = 10;
   localparam int CNT_W_DEF       = 8;
   localparam int RESULT_LAT_DEF  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WPOP   = 3'd1,
      WLOAD  = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4,
      FIN    = 3'd5
   } state_t;
endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for valid strobes; any_valid reports whether
// any strobe is still travelling through the line.
module valid_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             any_valid
);
   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      end else begin
         stage[0] <= din;
         for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
      end
   end

   assign dout = stage[DEPTH-1];

   always_comb begin
      any_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) any_valid = any_valid | (|stage[k]);
   end
endmodule

// File: rtl/vec_mul_sequencer.sv
// Sequences one matrix-vector job: optional weight-tile reload, streaming of
// UB read addresses, and result-buffer writes after the array latency.
//
// Handshake: start is a single-cycle request taken only while busy=0; there
// is no backpressure, so every issued vector produces exactly one write
// RESULT_LAT cycles after its UB address appears.
module vec_mul_sequencer
   import vec_mul_pkg::*;
#(
   parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int RESULT_LAT  = RESULT_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   reload,
   input  logic [CNT_W-1:0]       num_vecs,
   input  logic [ADDRESSSIZE-1:0] src_base,
   input  logic [ADDRESSSIZE-1:0] dst_base,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   output logic                   weight_reload,
   output logic [ADDRESSSIZE-1:0] ub_address,
   output logic                   res_write_enable,
   output logic [ADDRESSSIZE-1:0] res_address,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [2:0]             state_dbg
);
   state_t                 state, state_next;
   logic [CNT_W-1:0]       n_q, rem, rem_next, job_n;
   logic [ADDRESSSIZE-1:0] src_q, dst_q, wr_cnt, ub_next, job_src;
   logic                   issue, err_next, line_out, line_any;

   assign state_dbg = state;

   always_comb begin
      state_next = state;
      rem_next   = rem;
      ub_next    = ub_address;
      err_next   = 1'b0;
      // In IDLE the job fields are still on the inputs, not yet latched.
      job_n      = (state == IDLE) ? num_vecs : n_q;
      job_src    = (state == IDLE) ? src_base : src_q;
      case (state)
         IDLE: begin
            if (start) begin
               if (reload) begin
                  if (fifo_empty) err_next = 1'b1;
                  else            state_next = WPOP;
               end else if (job_n == '0) begin
                  state_next = FIN;
               end else begin
                  state_next = STREAM;
               end
            end
         end
         WPOP:  state_next = WLOAD;
         WLOAD: state_next = (job_n == '0) ? FIN : STREAM;
         STREAM: begin
            if (rem == '0) begin
               state_next = DRAIN;
            end else begin
               rem_next = rem - CNT_W'(1);
               ub_next  = ub_address + ADDRESSSIZE'(1);
            end
         end
         DRAIN: if (!line_any) state_next = FIN;
         FIN:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (state != STREAM && state_next == STREAM) begin
         rem_next = job_n - CNT_W'(1);
         ub_next  = job_src;
      end
      issue = (state_next == STREAM);
   end

   // The strobe enters the line on the same edge its UB address is registered.
   valid_delay_line #(.DEPTH(RESULT_LAT), .WIDTH(1)) u_vdl (
      .clk       (clk),
      .rstn      (rstn),
      .din       (issue),
      .dout      (line_out),
      .any_valid (line_any)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state            <= IDLE;
         rem              <= '0;
         n_q              <= '0;
         src_q            <= '0;
         dst_q            <= '0;
         wr_cnt           <= '0;
         ub_address       <= '0;
         res_address      <= '0;
         fifo_read_enable <= 1'b0;
         weight_reload    <= 1'b0;
         res_write_enable <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         err              <= 1'b0;
      end else begin
         state            <= state_next;
         rem              <= rem_next;
         ub_address       <= ub_next;
         fifo_read_enable <= (state_next == WPOP);
         weight_reload    <= (state_next == WLOAD);
         busy             <= (state_next != IDLE);
         done             <= (state == FIN);
         err              <= err_next;
         res_write_enable <= line_out;
         if (state == IDLE && start) begin
            n_q    <= num_vecs;
            src_q  <= src_base;
            dst_q  <= dst_base;
            wr_cnt <= '0;
         end
         if (line_out) begin
            res_address <= dst_q + wr_cnt;
            wr_cnt      <= wr_cnt + ADDRESSSIZE'(1);
         end
      end
   end
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Scoreboard bench for vec_mul_sequencer: a cycle-level reference model
// queues expected events, a negedge monitor pops and compares them.
module tb_vec_mul_sequencer;
   localparam int AW = 10;
   localparam int CW = 8;
   localparam int RL = 2;
   localparam int P_FRE = 0, P_WRL = 1, P_DONE = 2, P_ERR = 3;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
   } ev_t;

   logic          clk = 1'b0;
   logic          rstn, start, reload, fifo_empty;
   logic [CW-1:0] num_vecs;
   logic [AW-1:0] src_base, dst_base;
   logic          fifo_read_enable, weight_reload, res_write_enable;
   logic [AW-1:0] ub_address, res_address;
   logic          busy, done, err;
   logic [2:0]    state_dbg;

   int   cyc = 0;
   bit   rst_seen = 1'b0;
   int   total = 0;
   int   bad = 0;
   ev_t  rd_q[$];
   ev_t  exp_q[$];
   int   pq[4][$];
   int   busy_lo = 0;
   int   busy_hi = -1;
   logic [AW-1:0] exp_ub = '0;
   string pname[4] = '{"fifo_read_enable", "weight_reload", "done", "err"};

   vec_mul_sequencer #(.ADDRESSSIZE(AW), .CNT_W(CW), .RESULT_LAT(RL)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .reload           (reload),
      .num_vecs         (num_vecs),
      .src_base         (src_base),
      .dst_base         (dst_base),
      .fifo_empty       (fifo_empty),
      .fifo_read_enable (fifo_read_enable),
      .weight_reload    (weight_reload),
      .ub_address       (ub_address),
      .res_write_enable (res_write_enable),
      .res_address      (res_address),
      .busy             (busy),
      .done             (done),
      .err              (err),
      .state_dbg        (state_dbg)
   );

   // clock / reset bookkeeping
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !rstn;
   end

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic flag(input string name, input string what);
      total++;
      bad++;
      $display("FAIL %s: %s at cycle %0d", name, what, cyc);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [3:0] psig;
      ev_t        e;
      if (rst_seen) begin
         check("reset_outputs",
               {fifo_read_enable, weight_reload, ub_address, res_write_enable,
                res_address, busy, done, err, state_dbg}, 0);
         rd_q.delete();
         exp_q.delete();
         for (int k = 0; k < 4; k++) pq[k].delete();
         exp_ub  = '0;
         busy_hi = -1;
      end else begin
         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            e = rd_q.pop_front();
            exp_ub = e.addr;
         end
         check("ub_address", ub_address, exp_ub);

         if (res_write_enable) begin
            if (exp_q.size() == 0) flag("res_write", "unexpected write");
            else begin
               e = exp_q.pop_front();
               check("res_write_cycle", cyc, e.cyc);
               check("res_address", res_address, e.addr);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            flag("res_write", $sformatf("missing write for cycle %0d", exp_q[0].cyc));
            void'(exp_q.pop_front());
         end

         psig = {err, done, weight_reload, fifo_read_enable};
         for (int k = 0; k < 4; k++) begin
            if (psig[k]) begin
               if (pq[k].size() == 0) flag(pname[k], "unexpected pulse");
               else check(pname[k], cyc, pq[k].pop_front());
            end else if (pq[k].size() > 0 && pq[k][0] <= cyc) begin
               flag(pname[k], $sformatf("missing pulse for cycle %0d", pq[k][0]));
               void'(pq[k].pop_front());
            end
         end

         check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      end
   end

   // driver: reference model computes every event time from the job fields
   task automatic issue_job(input bit rl, input int n, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input bit fe, output int done_c);
      int  t0, base;
      ev_t e;
      t0         = cyc;
      done_c     = t0 + 3;
      start      = 1'b1;
      reload     = rl;
      num_vecs   = n[CW-1:0];
      src_base   = src;
      dst_base   = dst;
      fifo_empty = fe;
      if (rl && fe) begin
         pq[P_ERR].push_back(t0 + 1);
      end else begin
         base = t0 + 1 + (rl ? 2 : 0);
         if (rl) begin
            pq[P_FRE].push_back(t0 + 1);
            pq[P_WRL].push_back(t0 + 2);
         end
         for (int i = 0; i < n; i++) begin
            e.cyc  = base + i;
            e.addr = src + AW'(i);
            rd_q.push_back(e);
            e.cyc  = base + i + RL;
            e.addr = dst + AW'(i);
            exp_q.push_back(e);
         end
         done_c = (n == 0) ? t0 + 2 : t0 + n + RL + 2;
         if (rl) done_c += 2;
         pq[P_DONE].push_back(done_c);
         busy_lo = t0 + 1;
         busy_hi = done_c - 1;
      end
      @(posedge clk); #1;
      start      = 1'b0;
      reload     = 1'b0;
      fifo_empty = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic run_job(input bit rl, input int n, input logic [AW-1:0] src,
                          input logic [AW-1:0] dst, input bit fe);
      int dc;
      issue_job(rl, n, src, dst, fe, dc);
      wait_until(dc + 1 + $urandom_range(0, 2));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rstn       = 1'b0;
      start      = 1'b0;
      reload     = 1'b0;
      fifo_empty = 1'b0;
      num_vecs   = '0;
      src_base   = '0;
      dst_base   = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      step();

      run_job(1'b1, 4, 10'h010, 10'h020, 1'b0);
      run_job(1'b1, 4, 10'h100, 10'h200, 1'b1);
      run_job(1'b0, 0, 10'h055, 10'h066, 1'b0);
      run_job(1'b1, 0, 10'h077, 10'h088, 1'b0);
      run_job(1'b0, 3, 10'h3FE, 10'h3FF, 1'b0);

      // reset during STREAM, then a fresh job
      issue_job(1'b0, 8, 10'h040, 10'h080, 1'b0, dc);
      step();
      step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      repeat (4) step();
      run_job(1'b0, 3, 10'h0A0, 10'h0B0, 1'b0);

      // start pulsed while busy is ignored
      issue_job(1'b1, 5, 10'h123, 10'h321, 1'b0, dc);
      repeat (3) step();
      start    = 1'b1;
      reload   = 1'b0;
      num_vecs = 8'd2;
      src_base = 10'h200;
      dst_base = 10'h300;
      step();
      start = 1'b0;
      wait_until(dc + 2);

      for (int j = 0; j < 14; j++) begin
         run_job(1'($urandom_range(0, 1)), $urandom_range(0, 12),
                 AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
                 ($urandom_range(0, 5) == 0));
      end

      repeat (4) step();
      check("pending_reads", rd_q.size(), 0);
      check("pending_writes", exp_q.size(), 0);
      for (int k = 0; k < 4; k++) check({"pending_", pname[k]}, pq[k].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vec_mul_sequencer.md
VEC_MUL_SEQUENCER -- requirements
Module: vec_mul_sequencer

Interface
REQ-001 Parameter ADDRESSSIZE, default 10, SHALL set the width of unified-buffer and result-buffer addresses.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the vector-count field.
REQ-003 Parameter RESULT_LAT, default 2, range 1..8, SHALL set the cycles from the UB address issue to a valid result at the array output.
REQ-004 clk  input  1  the single clock; all logic is rising-edge.
REQ-005 rstn  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to run a job; sampled only in IDLE.
REQ-007 reload  input  1  weight-reload request for the job; sampled with start.
REQ-008 num_vecs  input  CNT_W  number of input vectors in the job; sampled with start.
REQ-009 src_base  input  ADDRESSSIZE  first UB read address; sampled with start.
REQ-010 dst_base  input  ADDRESSSIZE  first result-buffer write address; sampled with start.
REQ-011 fifo_empty  input  1  weight FIFO empty flag.
REQ-012 fifo_read_enable  output  1  pops one weight tile from the FIFO.
REQ-013 weight_reload  output  1  latches the FIFO output tile into the array.
REQ-014 ub_address  output  ADDRESSSIZE  unified-buffer read address.
REQ-015 res_write_enable  output  1  result-buffer write strobe.
REQ-016 res_address  output  ADDRESSSIZE  result-buffer write address.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse on job completion.
REQ-019 err  output  1  one-cycle pulse when a job is rejected.

Function
REQ-020 The FSM SHALL have the states IDLE, WPOP, WLOAD, STREAM, DRAIN and FIN.
REQ-021 IDLE with start=1 and reload=1 and fifo_empty=0 SHALL go to WPOP.
REQ-022 IDLE with start=1 and reload=0 SHALL go to STREAM.
REQ-023 IDLE with start=1 and reload=1 and fifo_empty=1 SHALL pulse err the next cycle and remain in IDLE.
REQ-024 In WPOP, fifo_read_enable SHALL be 1 for exactly one cycle, and the FSM SHALL then go to WLOAD.
REQ-025 In WLOAD, weight_reload SHALL be 1 for exactly one cycle, and the FSM SHALL then go to STREAM.
REQ-026 In STREAM, the FSM SHALL issue one vector per cycle at ub_address = src_base + i, for i = 0..num_vecs-1.
REQ-027 After the last issue, the FSM SHALL go to DRAIN.
REQ-028 An issue strobe SHALL pass through a RESULT_LAT-stage valid delay line; each strobe emerging from the line SHALL assert res_write_enable at res_address = dst_base + j, with j incrementing per write.
REQ-029 DRAIN SHALL hold until the delay line is empty and SHALL then go to FIN.
REQ-030 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-031 When num_vecs = 0, the FSM SHALL skip STREAM and DRAIN, go IDLE -> (WPOP -> WLOAD if reload) -> FIN, and issue no writes.
REQ-032 Address arithmetic SHALL be unsigned and wrap modulo 2^ADDRESSSIZE; wrap SHALL NOT be flagged.
REQ-033 start while busy=1 SHALL be ignored with no err pulse.
REQ-034 Latency from the start cycle to the done pulse SHALL be num_vecs + RESULT_LAT + 2 cycles (+2 with reload).
REQ-035 ub_address SHALL hold its last issued value outside STREAM.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rstn=0 at a clock edge SHALL force IDLE, clear the delay line and counters, and drive all outputs to 0.
REQ-038 A reset mid-job SHALL abort the job with no further writes and no done pulse.

Structure
REQ-039 Package vec_mul_pkg SHALL hold the state enumeration and the default values of ADDRESSSIZE, CNT_W and RESULT_LAT.
REQ-040 The valid delay line SHALL be a sub-module valid_delay_line (parameters DEPTH and WIDTH=1), with an any-valid output used by DRAIN.

Verification
REQ-041 Scenario: reload=1, num_vecs=4, src_base=0x010, dst_base=0x020, fifo_empty=0, RESULT_LAT=2 -> one fifo_read_enable, then one weight_reload, UB reads at 0x010..0x013, writes at 0x020..0x023, done 10 cycles after start.
REQ-042 Scenario: reload=1, fifo_empty=1 -> err pulse, busy stays 0, no reads or writes.
REQ-043 Scenario: num_vecs=0, reload=0 -> done 2 cycles after start, res_write_enable never 1.
REQ-044 Scenario: src_base=0x3FE, dst_base=0x3FF, num_vecs=3 -> reads at 0x3FE, 0x3FF, 0x000 and writes at 0x3FF, 0x000, 0x001.
REQ-045 Scenario: rstn=0 for one cycle during STREAM of num_vecs=8 -> next cycle IDLE, all outputs 0, no done; a fresh job then completes normally.
REQ-046 Scenario: second start pulsed while busy -> ignored; exactly one done and num_vecs writes.
